// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared states, register map and output decode for the
//                SoC reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_PLL  = 3'd0,
        S_DRAM_RST  = 3'd1,
        S_WAIT_DRAM = 3'd2,
        S_CORE_RST  = 3'd3,
        S_RUN       = 3'd4,
        S_NDM_RST   = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam logic c_addr_ctrl   = 1'b0;
    localparam logic c_addr_reason = 1'b1;

    localparam int c_ctrl_ndm_bit  = 0;
    localparam int c_ctrl_full_bit = 1;
    localparam int c_ctrl_err_bit  = 2;

    localparam int c_rsn_por      = 0;
    localparam int c_rsn_dbg      = 1;
    localparam int c_rsn_sw_ndm   = 2;
    localparam int c_rsn_sw_full  = 3;
    localparam int c_rsn_dram_err = 4;
    localparam int c_rsn_w        = 5;

    localparam logic [c_rsn_w-1:0] c_rsn_reset = 5'h01;

    typedef struct packed {
        logic dm_rst_n;
        logic ndm_rst_n;
        logic dram_rst_n;
        logic done_led;
        logic err_led;
    } rst_outs_t;

    // Output levels are a pure function of the state being entered, so
    // registering this decode gives glitch-free reset lines.
    function automatic rst_outs_t outs_for(input state_t s, input logic dram_active);
        rst_outs_t o;
        o = '0;
        case (s)
            S_WAIT_DRAM: o.dram_rst_n = 1'b1;
            S_CORE_RST:  o.dram_rst_n = dram_active;
            S_RUN: begin
                o.dm_rst_n   = 1'b1;
                o.ndm_rst_n  = 1'b1;
                o.dram_rst_n = dram_active;
                o.done_led   = 1'b1;
            end
            S_NDM_RST: begin
                o.dm_rst_n   = 1'b1;
                o.dram_rst_n = dram_active;
            end
            S_ERR: begin
                o.dm_rst_n   = 1'b1;
                o.dram_rst_n = dram_active;
                o.err_led    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_wb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_wb_regs
//  Description : Wishbone slave for the reset sequencer: CTRL request decode,
//                single-cycle ack and the sticky W1C reset-reason register.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_wb_regs
    import reset_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_adr,
    input  logic [31:0]        i_dat_w,
    input  logic [3:0]         i_sel,
    input  logic               i_cyc,
    input  logic               i_stb,
    input  logic               i_we,
    output logic [31:0]        o_dat_r,
    output logic               o_ack,
    output logic               o_stall,
    input  logic               i_state_is_err,
    input  logic [c_rsn_w-1:0] i_rsn_set,
    output logic               o_sw_ndm,
    output logic               o_sw_full,
    output logic [c_rsn_w-1:0] o_reason
);

    logic               w_req;
    logic               w_wr0;
    logic               w_ctrl_wr;
    logic [c_rsn_w-1:0] w_rsn_clr;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    logic [c_rsn_w-1:0] r_reason;
    logic               r_ack;
    logic [31:0]        r_dat_r;

    assign w_req     = i_cyc & i_stb;
    assign w_wr0     = w_req & i_we & i_sel[0];
    assign w_ctrl_wr = w_wr0 & (i_adr == c_addr_ctrl);
    assign w_rsn_clr = (w_wr0 && (i_adr == c_addr_reason)) ? i_dat_w[c_rsn_w-1:0] : '0;

    assign o_sw_full = w_ctrl_wr & i_dat_w[c_ctrl_full_bit];
    assign o_sw_ndm  = w_ctrl_wr & i_dat_w[c_ctrl_ndm_bit];

    assign w_rd_data = (i_adr == c_addr_reason) ? {27'b0, r_reason}
                                                : (32'(i_state_is_err) << c_ctrl_err_bit);

    assign w_unused = &{1'b0, i_dat_w[31:c_rsn_w], i_sel[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reason <= c_rsn_reset;
            r_ack    <= 1'b0;
            r_dat_r  <= '0;
        end else begin
            // Hardware set is applied after the clear so it wins a same-cycle race.
            r_reason <= (r_reason & ~w_rsn_clr) | i_rsn_set;
            r_ack    <= w_req;
            r_dat_r  <= w_req ? w_rd_data : '0;
        end
    end

    assign o_dat_r  = r_dat_r;
    assign o_ack    = r_ack;
    assign o_stall  = 1'b0;
    assign o_reason = r_reason;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Sequences SoC resets after PLL lock, DRAM calibration, debug
//                and software requests; drives the init status LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int DRAM_TIMEOUT_CYCLES = 2**20,
    parameter bit DRAM_ACTIVE         = 1'b1
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        dram_init_done,
    input  logic        dram_init_err,
    input  logic        ndm_reset_req,
    input  logic        wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        dm_rst_n,
    output logic        ndm_rst_n,
    output logic        dram_rst_n,
    output logic        init_done_led,
    output logic        init_err_led
);

    localparam int c_cnt_max = (RST_HOLD_CYCLES > DRAM_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES
                                                                       : DRAM_TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_hold = c_cnt_w'(RST_HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_tmo  = c_cnt_w'(DRAM_TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [1:0]         r_pll_sync;
    logic               r_ndm_req_d;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    rst_outs_t          r_outs;

    logic               w_pll_ok;
    logic               w_ndm_rise;
    logic               w_sw_ndm;
    logic               w_sw_full;
    logic               w_cnt_last;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_rsn_w-1:0] w_rsn_set;
    logic [c_rsn_w-1:0] w_reason;

    assign w_pll_ok   = r_pll_sync[1];
    assign w_ndm_rise = ndm_reset_req & ~r_ndm_req_d;
    assign w_cnt_last = (r_cnt == c_one);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_sync  <= 2'b00;
            r_ndm_req_d <= 1'b0;
        end else begin
            r_pll_sync  <= {r_pll_sync[0], pll_locked};
            r_ndm_req_d <= ndm_reset_req;
        end
    end

    // Hold states are left on the cycle the counter would reach zero, so each
    // reset pulse lasts exactly the loaded number of cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rsn_set   = '0;
        case (r_state)
            S_WAIT_PLL: begin
                if (w_pll_ok) begin
                    w_state_nxt = DRAM_ACTIVE ? S_DRAM_RST : S_CORE_RST;
                    w_cnt_nxt   = c_hold;
                end
            end
            S_DRAM_RST: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_WAIT_DRAM;
                    w_cnt_nxt   = c_tmo;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            S_WAIT_DRAM: begin
                if (dram_init_err) begin
                    w_state_nxt                = S_ERR;
                    w_rsn_set[c_rsn_dram_err]  = 1'b1;
                end else if (dram_init_done) begin
                    w_state_nxt = S_CORE_RST;
                    w_cnt_nxt   = c_hold;
                end else if (w_cnt_last) begin
                    w_state_nxt                = S_ERR;
                    w_rsn_set[c_rsn_dram_err]  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            S_CORE_RST: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            S_RUN: begin
                if (w_sw_full) begin
                    w_state_nxt               = S_WAIT_PLL;
                    w_rsn_set[c_rsn_sw_full]  = 1'b1;
                end else if (!w_pll_ok) begin
                    w_state_nxt = S_WAIT_PLL;
                end else if (w_ndm_rise || w_sw_ndm) begin
                    w_state_nxt              = S_NDM_RST;
                    w_cnt_nxt                = c_hold;
                    w_rsn_set[c_rsn_dbg]     = w_ndm_rise;
                    w_rsn_set[c_rsn_sw_ndm]  = w_sw_ndm;
                end
            end
            S_NDM_RST: begin
                // Requests are dropped here but still leave a trace in REASON.
                w_rsn_set[c_rsn_dbg]     = w_ndm_rise;
                w_rsn_set[c_rsn_sw_ndm]  = w_sw_ndm;
                w_rsn_set[c_rsn_sw_full] = w_sw_full;
                if (w_cnt_last) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            S_ERR: begin
                if (w_sw_full) begin
                    w_state_nxt              = S_WAIT_PLL;
                    w_rsn_set[c_rsn_sw_full] = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT_PLL;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT_PLL;
            r_cnt   <= '0;
            r_outs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_outs  <= outs_for(w_state_nxt, DRAM_ACTIVE);
        end
    end

    reset_seq_wb_regs u_wb_regs (
        .clk            (sys_clk),
        .rst_n          (rst_n),
        .i_adr          (wb_adr),
        .i_dat_w        (wb_dat_w),
        .i_sel          (wb_sel),
        .i_cyc          (wb_cyc),
        .i_stb          (wb_stb),
        .i_we           (wb_we),
        .o_dat_r        (wb_dat_r),
        .o_ack          (wb_ack),
        .o_stall        (wb_stall),
        .i_state_is_err (r_state == S_ERR),
        .i_rsn_set      (w_rsn_set),
        .o_sw_ndm       (w_sw_ndm),
        .o_sw_full      (w_sw_full),
        .o_reason       (w_reason)
    );

    assign dm_rst_n      = r_outs.dm_rst_n;
    assign ndm_rst_n     = r_outs.ndm_rst_n;
    assign dram_rst_n    = r_outs.dram_rst_n;
    assign init_done_led = r_outs.done_led;
    assign init_err_led  = r_outs.err_led;

    logic w_unused_reason;
    assign w_unused_reason = &{1'b0, w_reason};

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Randomised self-checking bench for reset_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int TMO  = 64;
    localparam int SYNC = 2;

    localparam int SIG_DRAM = 0;
    localparam int SIG_NDM  = 1;
    localparam int SIG_ERR  = 2;

    logic        sys_clk        = 1'b0;
    logic        rst_n          = 1'b0;
    logic        pll_locked     = 1'b0;
    logic        dram_init_done = 1'b0;
    logic        dram_init_err  = 1'b0;
    logic        ndm_reset_req  = 1'b0;
    logic        wb_adr         = 1'b0;
    logic [31:0] wb_dat_w       = '0;
    logic [3:0]  wb_sel         = '0;
    logic        wb_cyc         = 1'b0;
    logic        wb_stb         = 1'b0;
    logic        wb_we          = 1'b0;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_stall;
    logic        dm_rst_n, ndm_rst_n, dram_rst_n, init_done_led, init_err_led;

    reset_sequencer #(
        .RST_HOLD_CYCLES     (HOLD),
        .DRAM_TIMEOUT_CYCLES (TMO),
        .DRAM_ACTIVE         (1'b1)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .dram_init_done (dram_init_done),
        .dram_init_err  (dram_init_err),
        .ndm_reset_req  (ndm_reset_req),
        .wb_adr         (wb_adr),
        .wb_dat_w       (wb_dat_w),
        .wb_dat_r       (wb_dat_r),
        .wb_sel         (wb_sel),
        .wb_cyc         (wb_cyc),
        .wb_stb         (wb_stb),
        .wb_we          (wb_we),
        .wb_ack         (wb_ack),
        .wb_stall       (wb_stall),
        .dm_rst_n       (dm_rst_n),
        .ndm_rst_n      (ndm_rst_n),
        .dram_rst_n     (dram_rst_n),
        .init_done_led  (init_done_led),
        .init_err_led   (init_err_led)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [4:0] m_reason;

    int   mon_ndm_low   = 0;
    int   mon_ndm_falls = 0;
    int   mon_dm_low    = 0;
    logic mon_ndm_prev  = 1'b0;

    always @(negedge sys_clk) begin
        if (!ndm_rst_n) mon_ndm_low <= mon_ndm_low + 1;
        if (!dm_rst_n) mon_dm_low <= mon_dm_low + 1;
        if (mon_ndm_prev && !ndm_rst_n) mon_ndm_falls <= mon_ndm_falls + 1;
        mon_ndm_prev <= ndm_rst_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int which);
        case (which)
            SIG_DRAM: return dram_rst_n;
            SIG_NDM:  return ndm_rst_n;
            SIG_ERR:  return init_err_led;
            default:  return init_done_led;
        endcase
    endfunction

    task automatic idle(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    // Returns the number of clock edges until the signal shows lvl, or -1.
    task automatic wait_for(input int which, input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (pick(which) !== lvl && n < budget);
        if (pick(which) !== lvl) n = -1;
    endtask

    task automatic wb_xfer(input logic adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        @(negedge sys_clk);
        check("wb_ack", {31'b0, wb_ack}, 32'd1);
        rd = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] rd;
        wb_xfer(adr, 1'b1, dat, sel, rd);
    endtask

    task automatic wb_read(input logic adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        wb_xfer(adr, 1'b0, 32'h0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    task automatic check_pulse(input string tag, input int b_falls, input int b_low, input int b_dm);
        check({tag, "_falls"}, mon_ndm_falls - b_falls, 1);
        check({tag, "_low"}, mon_ndm_low - b_low, HOLD);
        check({tag, "_dm"}, mon_dm_low - b_dm, 0);
    endtask

    task automatic hw_ndm_pulse(input int width);
        int bf, bl, bd;
        bf = mon_ndm_falls; bl = mon_ndm_low; bd = mon_dm_low;
        ndm_reset_req = 1'b1;
        idle(width);
        ndm_reset_req = 1'b0;
        idle(HOLD + 4);
        m_reason[1] = 1'b1;
        check_pulse("hw_ndm", bf, bl, bd);
    endtask

    task automatic sw_ndm_pulse();
        int bf, bl, bd;
        bf = mon_ndm_falls; bl = mon_ndm_low; bd = mon_dm_low;
        wb_write(1'b0, ($urandom & ~32'h2) | 32'h1, 4'h1 | 4'($urandom_range(0, 15)));
        idle(HOLD + 4);
        m_reason[2] = 1'b1;
        check_pulse("sw_ndm", bf, bl, bd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bf, bl, bd;
        logic [31:0] mask;
        logic [3:0]  sel;
        m_reason = 5'h01;

        // Reset values
        idle(5);
        check("reset_outs", {26'b0, dm_rst_n, ndm_rst_n, dram_rst_n, init_done_led, init_err_led, wb_ack}, 32'h0);
        check("reset_dat_r", wb_dat_r, 32'h0);
        rst_n = 1'b1;
        idle($urandom_range(3, 20));
        check("prelock_outs", {27'b0, dm_rst_n, ndm_rst_n, dram_rst_n, init_done_led, init_err_led}, 32'h0);

        // Power-up sequence
        pll_locked = 1'b1;
        wait_for(SIG_DRAM, 1'b1, 200, n);
        check("lock_to_dram", n, SYNC + 1 + HOLD);
        check("core_held", {30'b0, dm_rst_n, ndm_rst_n}, 32'h0);
        idle($urandom_range(1, 30));
        dram_init_done = 1'b1;
        wait_for(SIG_NDM, 1'b1, 200, n);
        check("done_to_run", n, 1 + HOLD);
        check("run_outs", {28'b0, dm_rst_n, dram_rst_n, init_done_led, init_err_led}, 32'he);
        wb_read(1'b1, {27'b0, m_reason}, "reason_por");

        // Back-to-back reads
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 1'b1; wb_sel = 4'hF;
        @(negedge sys_clk);
        check("b2b_ack0", {31'b0, wb_ack}, 32'd1);
        check("b2b_dat0", wb_dat_r, {27'b0, m_reason});
        wb_adr = 1'b0;
        @(negedge sys_clk);
        check("b2b_ack1", {31'b0, wb_ack}, 32'd1);
        check("b2b_dat1", wb_dat_r, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge sys_clk);
        check("b2b_ack_drop", {31'b0, wb_ack}, 32'd0);

        // Debug-module requests: short pulse and long hold
        hw_ndm_pulse(1);
        hw_ndm_pulse(200);
        wb_read(1'b1, {27'b0, m_reason}, "reason_dbg");

        // Randomised operations in RUN
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: hw_ndm_pulse($urandom_range(1, 40));
                1: sw_ndm_pulse();
                2: begin
                    mask = $urandom;
                    sel  = 4'($urandom_range(0, 15));
                    wb_write(1'b1, mask, sel);
                    if (sel[0]) m_reason = m_reason & ~mask[4:0];
                end
                default: wb_read(1'b0, 32'h0, "ctrl_run");
            endcase
            wb_read(1'b1, {27'b0, m_reason}, "reason_rand");
        end

        // Requests arriving during NDM_RST are ignored but recorded
        wb_write(1'b1, 32'h6, 4'h1);
        m_reason = m_reason & ~5'h06;
        wb_read(1'b1, {27'b0, m_reason}, "reason_clr6");
        bf = mon_ndm_falls; bl = mon_ndm_low; bd = mon_dm_low;
        wb_write(1'b0, 32'h1, 4'h1);
        idle(3);
        ndm_reset_req = 1'b1;
        idle(2);
        ndm_reset_req = 1'b0;
        idle(HOLD + 4);
        m_reason = m_reason | 5'h06;
        check_pulse("ndm_ignored", bf, bl, bd);
        wb_read(1'b1, {27'b0, m_reason}, "reason_ignored");

        // Full software reset with both CTRL bits
        dram_init_done = 1'b0;
        wb_write(1'b0, 32'h3, 4'hF);
        m_reason[3] = 1'b1;
        check("full_outs", {28'b0, dm_rst_n, ndm_rst_n, dram_rst_n, init_done_led}, 32'h0);
        wait_for(SIG_DRAM, 1'b1, 200, n);
        check("full_to_dram", n, 1 + HOLD);
        idle(2);
        dram_init_done = 1'b1;
        @(negedge sys_clk);
        check("core_dm_low", {31'b0, dm_rst_n}, 32'd0);
        wait_for(SIG_NDM, 1'b1, 200, n);
        check("core_to_run", n, HOLD);
        check("full_dm_up", {31'b0, dm_rst_n}, 32'd1);
        wb_read(1'b1, {27'b0, m_reason}, "reason_full");
        wb_write(1'b1, 32'h1F, 4'h1);
        m_reason = 5'h00;
        wb_read(1'b1, 32'h0, "reason_w1c_all");

        // DRAM calibration timeout
        dram_init_done = 1'b0;
        wb_write(1'b0, 32'h2, 4'h1);
        m_reason[3] = 1'b1;
        wait_for(SIG_DRAM, 1'b1, 200, n);
        check("tmo_dram", n, 1 + HOLD);
        wait_for(SIG_ERR, 1'b1, 500, n);
        check("tmo_to_err", n, TMO);
        m_reason[4] = 1'b1;
        check("err_outs", {29'b0, dm_rst_n, ndm_rst_n, init_done_led}, 32'h4);
        wb_read(1'b0, 32'h4, "ctrl_err");
        wb_read(1'b1, {27'b0, m_reason}, "reason_err");
        wb_write(1'b1, 32'h10, 4'h1);
        m_reason[4] = 1'b0;
        wb_read(1'b1, {27'b0, m_reason}, "reason_clr_err");

        // Restart from ERR; error and done together: error wins
        wb_write(1'b0, 32'h2, 4'h1);
        check("err_exit_led", {31'b0, init_err_led}, 32'd0);
        wait_for(SIG_DRAM, 1'b1, 200, n);
        check("restart_dram", n, 1 + HOLD);
        dram_init_err = 1'b1;
        dram_init_done = 1'b1;
        wait_for(SIG_ERR, 1'b1, 10, n);
        check("err_beats_done", n, 1);
        m_reason[4] = 1'b1;
        dram_init_err = 1'b0;
        dram_init_done = 1'b0;
        wb_read(1'b1, {27'b0, m_reason}, "reason_err2");

        // Back to RUN
        wb_write(1'b0, 32'h2, 4'h1);
        wait_for(SIG_DRAM, 1'b1, 200, n);
        dram_init_done = 1'b1;
        wait_for(SIG_NDM, 1'b1, 200, n);
        check("rerun_done", n, 1 + HOLD);

        // PLL lock loss and relock
        pll_locked = 1'b0;
        wait_for(SIG_NDM, 1'b0, 20, n);
        check("pll_loss", n, SYNC + 1);
        check("pll_loss_outs", {29'b0, dm_rst_n, dram_rst_n, init_done_led}, 32'h0);
        dram_init_done = 1'b0;
        idle($urandom_range(2, 10));
        pll_locked = 1'b1;
        wait_for(SIG_DRAM, 1'b1, 200, n);
        check("relock_dram", n, SYNC + 1 + HOLD);
        dram_init_done = 1'b1;
        wait_for(SIG_NDM, 1'b1, 200, n);
        check("relock_run", n, 1 + HOLD);
        wb_read(1'b1, {27'b0, m_reason}, "reason_relock");

        // Asynchronous reset while in WAIT_DRAM
        dram_init_done = 1'b0;
        wb_write(1'b0, 32'h2, 4'h1);
        m_reason[3] = 1'b1;
        wait_for(SIG_DRAM, 1'b1, 200, n);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_outs", {26'b0, dm_rst_n, ndm_rst_n, dram_rst_n, init_done_led, init_err_led, wb_ack}, 32'h0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        m_reason = 5'h01;
        wb_read(1'b1, {27'b0, m_reason}, "reason_after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences all SoC-internal resets after power-on, PLL lock, DRAM calibration, debug-module requests and software requests; drives the init status LEDs.
- Sits inside boxlambda_soc between the clock generator / DRAM controller and every reset-consuming block.
- Has a small Wishbone slave for software-triggered resets and a sticky reset-reason register.

Parameters:
- RST_HOLD_CYCLES, 16, cycles each reset output is held asserted per pulse (min 2).
- DRAM_TIMEOUT_CYCLES, 2**20, max cycles in WAIT_DRAM before the error state.
- DRAM_ACTIVE, 1, 0 = skip DRAM_RST/WAIT_DRAM entirely.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- pll_locked  in  1  async PLL lock; 2-flop synchronised internally.
- dram_init_done  in  1  DRAM calibration complete (sys_clk domain).
- dram_init_err  in  1  DRAM calibration failed.
- ndm_reset_req  in  1  debug-module non-debug reset request, level.
- wb_adr  in  1  word address (0 = CTRL, 1 = REASON).
- wb_dat_w  in  32  write data.
- wb_dat_r  out  32  read data.
- wb_sel  in  4  byte selects; only byte 0 is used.
- wb_cyc, wb_stb, wb_we  in  1  each; Wishbone pipelined.
- wb_ack  out  1  single-cycle ack.
- wb_stall  out  1  tied 0.
- dm_rst_n  out  1  debug-module reset.
- ndm_rst_n  out  1  reset for everything except the debug module and this block.
- dram_rst_n  out  1  DRAM controller reset.
- init_done_led  out  1  high in RUN.
- init_err_led  out  1  high in ERR.

Behaviour:
- Reset values: dm_rst_n=0, ndm_rst_n=0, dram_rst_n=0, LEDs=0, wb_ack=0, wb_dat_r=0, REASON=0x01 (POR bit), state=WAIT_PLL, counter=0. All reset outputs are registered and glitch-free.
- FSM:
  - WAIT_PLL: all resets asserted. When pll_locked_sync=1, load counter with RST_HOLD_CYCLES and go to DRAM_RST, or to CORE_RST if DRAM_ACTIVE=0.
  - DRAM_RST: counter decrements. At 0: dram_rst_n=1, load counter with DRAM_TIMEOUT_CYCLES, go to WAIT_DRAM.
  - WAIT_DRAM: dram_init_done=1 loads counter with RST_HOLD_CYCLES and goes to CORE_RST. dram_init_err=1 or counter reaching 0 sets REASON[4] and goes to ERR. If done and err rise in the same cycle, err wins.
  - CORE_RST: dm_rst_n stays 0 only when entered via a full reset; otherwise dm_rst_n=1. At counter 0: ndm_rst_n=1, dm_rst_n=1, go to RUN.
  - RUN: init_done_led=1.
    - ndm_reset_req rising edge: set REASON[1], go to NDM_RST.
    - CTRL write with bit0=1: set REASON[2], go to NDM_RST.
    - CTRL write with bit1=1: set REASON[3], go to WAIT_PLL as a full reset. bit1 has priority over bit0 and over a same-cycle ndm_reset_req.
    - Loss of pll_locked_sync: go to WAIT_PLL.
  - NDM_RST: ndm_rst_n=0, dm_rst_n=1, dram_rst_n=1; hold RST_HOLD_CYCLES; then RUN. Requests arriving here are ignored; their reason bits are still set.
  - ERR: init_err_led=1, ndm_rst_n=0, dm_rst_n=1 (debugger stays usable). Only a full sw reset or rst_n exits.
- Full sw reset re-runs the whole sequence, but REASON is not cleared; only rst_n clears it.
- Wishbone:
  - Ack asserts the cycle after cyc&stb; back-to-back requests are accepted each cycle.
  - Read CTRL returns {29'b0, state_is_err, 2'b0}. Read REASON returns {27'b0, REASON[4:0]}.
  - A write to REASON with sel[0]=1 clears bits written as 1 (W1C). A simultaneous hardware set wins over the clear.
  - The bus stays live in every state; wb_* is clocked by sys_clk and reset only by rst_n.
- ndm_reset_req is edge-detected, so a held request causes one reset only.
- Counter width: $clog2(max(RST_HOLD_CYCLES, DRAM_TIMEOUT_CYCLES)+1).
- rst_n asserted mid-sequence: immediate asynchronous return to reset values.

Decomposition:
- Package reset_seq_pkg:
  - state enum (WAIT_PLL, DRAM_RST, WAIT_DRAM, CORE_RST, RUN, NDM_RST, ERR).
  - register addresses, CTRL bit indices, REASON bit indices (POR=0, DBG=1, SW_NDM=2, SW_FULL=3, DRAM_ERR=4).
- One sub-module: reset_seq_wb_regs (Wishbone decode, ack, REASON W1C/set merge). The FSM and counter stay in the top.

Test Plan:
- rst_n low 5 cycles, pll_locked high at cycle 20, dram_init_done at cycle 100 (RST_HOLD_CYCLES=16) -> dram_rst_n rises ~cycle 38, ndm_rst_n/dm_rst_n rise 16 cycles after done, init_done_led=1, REASON reads 0x01.
- In RUN, pulse ndm_reset_req 1 cycle, held high 200 cycles -> exactly one 16-cycle ndm_rst_n low pulse, dm_rst_n stays 1, REASON=0x03.
- Write CTRL=0x3 -> full sequence rerun with dm_rst_n low through CORE_RST, REASON bit3 set, ack 1 cycle after stb. Then W1C REASON with 0x1F -> reads 0x00.
- DRAM_TIMEOUT_CYCLES=64, dram_init_done never rises -> ERR after 64 cycles, init_err_led=1, REASON[4]=1, CTRL read=0x4. Write CTRL=0x2 -> sequence restarts.
- Drop pll_locked in RUN -> all resets asserted within 3 cycles. Relock -> normal sequence.
- Assert rst_n during WAIT_DRAM -> all outputs at reset values same cycle (async), REASON=0x01.
